fetch_stage_pp: RTL and testbench
=================================

Name: fetch_stage_pp

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipelined processor.
- Holds the PC and drives the instruction-memory address.
- Selects the next PC from sequential, jump (resolved in ID) or taken-branch (resolved in EX) sources.
- Registers the fetched word, with stall and flush, into the IF/ID latch whose instruction output feeds the ID-stage decoder.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, bubble word inserted into IF/ID on flush/reset (sll $0,$0,0).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
stall  in  1  hazard-unit stall; holds PC and IF/ID.
branch_taken  in  1  EX-stage branch resolved taken.
branch_target  in  32  EX-stage branch destination byte address.
jump_en  in  1  ID-stage decoded J/JAL.
jump_addr  in  26  Instr[25:0] of the instruction in ID.
imem_addr  out  32  instruction-memory byte address (= current PC).
imem_rdata  in  32  instruction word; combinational read of imem_addr, same cycle.
instr_id  out  32  IF/ID instruction to decoder.
pc_plus4_id  out  32  IF/ID copy of fetch PC+4.
valid_id  out  1  IF/ID holds a real instruction (0 = bubble).
fetch_count  out  32  number of instructions accepted into IF/ID.

Behaviour:
- Reset: all state updates on the rising clk edge where rst_n=0. Values: pc=RESET_PC, instr_id=NOP_INSTR, pc_plus4_id=0, valid_id=0, fetch_count=0.
- Reset mid-operation: same values next edge; it overrides stall, branch and jump.
- imem_addr = pc combinationally.
- pc_plus4 = pc + 32'd4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- Jump target = {pc_plus4_id[31:28], jump_addr, 2'b00}.
- jump_go = jump_en & valid_id & ~stall. A jump seen during a stall is ignored; it re-asserts when the stall releases.
- Next-PC priority, highest first:
  1. branch_taken: pc <= branch_target; IF/ID <= bubble. Stall is overridden.
  2. jump_go: pc <= jump target; IF/ID <= bubble. The delay slot is squashed.
  3. stall: pc and IF/ID hold.
  4. otherwise: pc <= pc_plus4; instr_id <= imem_rdata; pc_plus4_id <= pc_plus4; valid_id <= 1.
- Bubble means instr_id=NOP_INSTR, valid_id=0; pc_plus4_id is don't-care, driven 0.
- branch_taken and jump_en in the same cycle: the branch wins. The jump is younger and is flushed.
- fetch_count increments by 1 only on case 4 (new valid load). It wraps at 2^32.
- Latency: the word at PC N appears on instr_id one cycle after N is on imem_addr, given no stall or redirect.
- Redirect penalty: 1 bubble for a jump, 1 bubble for a branch in IF/ID. The ID/EX flush is handled by the downstream stage.
- No misalignment check: imem_addr[1:0] are passed through as-is.

Decomposition:
- Shared package pp_pkg holds:
  - NOP_INSTR and RESET_PC defaults
  - opcode constants (OP_RTYPE=6'h00, OP_J=6'h02, OP_JAL=6'h03, OP_BEQ=6'h04, OP_BNE=6'h05)
  - XLEN=32
- One natural sub-module: if_id_reg. It is the IF/ID latch with load/hold/flush controls and produces instr_id, pc_plus4_id and valid_id.
- PC register, next-PC mux and fetch_count stay in fetch_stage_pp.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release -> imem_addr=0, instr_id=0, valid_id=0, fetch_count=0. The next edge loads mem[0], pc_plus4_id=4, valid_id=1.
- Sequential fetch: memory holds words W0..W3, no stall -> instr_id shows W0,W1,W2,W3 on consecutive cycles, imem_addr 0,4,8,12, fetch_count=4.
- Stall: assert stall for 2 cycles while instr_id=W1 and pc=8 -> both held. On release, W2 loads; fetch_count does not advance during the stall.
- Jump:
  - Setup: pc_plus4_id=32'h1000_0008, jump_en=1, jump_addr=26'h0000040.
  - Response: next pc=32'h1000_0100 and IF/ID is a bubble (valid_id=0).
  - Same setup with stall=1 -> no redirect.
- Branch vs jump vs stall: branch_taken=1, branch_target=32'h0000_0200, jump_en=1 and stall=1 all in one cycle -> pc=32'h200, IF/ID bubble, fetch_count unchanged.
- Wrap and mid-run reset:
  - pc=32'hFFFF_FFFC with no stall -> next pc=0, pc_plus4_id=0.
  - rst_n=0 asserted during a running stall -> pc=RESET_PC and valid_id=0 on that edge.

Source files
------------

// File: rtl/pp_pkg.sv
// pp_pkg: shared constants for the 5-stage MIPS pipeline.
package pp_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline latch with load, hold and flush-to-bubble.
module if_id_reg
    import pp_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_plus4_in,
    output logic [XLEN-1:0] instr_id,
    output logic [XLEN-1:0] pc_plus4_id,
    output logic            valid_id
);
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            instr_id    <= NOP_INSTR;
            pc_plus4_id <= '0;
            valid_id    <= 1'b0;
        end else if (load) begin
            instr_id    <= instr_in;
            pc_plus4_id <= pc_plus4_in;
            valid_id    <= 1'b1;
        end
    end
endmodule

// File: rtl/fetch_stage_pp.sv
// fetch_stage_pp: PC register, next-PC selection and IF/ID latch.
module fetch_stage_pp
    import pp_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump_en,
    input  logic [25:0]     jump_addr,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_id,
    output logic [XLEN-1:0] pc_plus4_id,
    output logic            valid_id,
    output logic [XLEN-1:0] fetch_count
);
    logic [XLEN-1:0] pc, pc_plus4, jump_target, next_pc;
    logic            jump_go, flush, load;
    assign imem_addr   = pc;
    assign pc_plus4    = pc + 32'd4;
    assign jump_target = {pc_plus4_id[31:28], jump_addr, 2'b00};
    // A jump in ID is only real once the stall releases and the slot holds a valid instruction
    assign jump_go     = jump_en & valid_id & ~stall;
    assign flush       = branch_taken | jump_go;
    assign load        = ~flush & ~stall;
    always_comb begin
        next_pc = branch_taken ? branch_target :
                  jump_go      ? jump_target   :
                  stall        ? pc            : pc_plus4;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            fetch_count <= '0;
        end else begin
            pc          <= next_pc;
            fetch_count <= fetch_count + {31'd0, load};
        end
    end
    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .flush       (flush),
        .instr_in    (imem_rdata),
        .pc_plus4_in (pc_plus4),
        .instr_id    (instr_id),
        .pc_plus4_id (pc_plus4_id),
        .valid_id    (valid_id)
    );
endmodule

// File: tb/tb_fetch_stage_pp.sv
// tb_fetch_stage_pp: directed stimulus, per-cycle model comparison and literal checks.
module tb_fetch_stage_pp;
    logic        clk = 0;
    logic        rst_n = 0, stall = 0, branch_taken = 0, jump_en = 0;
    logic [31:0] branch_target = 0;
    logic [25:0] jump_addr = 0;
    logic [31:0] imem_addr, imem_rdata, instr_id, pc_plus4_id, fetch_count;
    logic        valid_id;
    int          passed = 0, total = 0;
    bit          started = 0;
    logic [31:0] m_pc, m_instr, m_pp4, m_cnt;
    logic        m_valid;

    always #5 clk = ~clk;

    // instruction memory: every address holds a distinct word
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction
    assign imem_rdata = mem(imem_addr);

    fetch_stage_pp dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .jump_en(jump_en), .jump_addr(jump_addr),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr_id(instr_id),
        .pc_plus4_id(pc_plus4_id), .valid_id(valid_id), .fetch_count(fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // reference model: what one clock edge must do to the architectural fetch state
    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 0; m_cnt = 0;
            started = 1;
        end else if (started) begin
            if (branch_taken) begin
                m_pc = branch_target; m_instr = 0; m_pp4 = 0; m_valid = 0;
            end else if (jump_en && m_valid && !stall) begin
                m_pc = {m_pp4[31:28], jump_addr, 2'b00}; m_instr = 0; m_pp4 = 0; m_valid = 0;
            end else if (!stall) begin
                m_instr = mem(m_pc); m_pp4 = m_pc + 4; m_valid = 1; m_cnt = m_cnt + 1; m_pc = m_pc + 4;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("instr_id", instr_id, m_instr);
            chk("pc_plus4_id", pc_plus4_id, m_pp4);
            chk("valid_id", {31'd0, valid_id}, {31'd0, m_valid});
            chk("fetch_count", fetch_count, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        tick(); tick();
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr_id, 32'h0);
        chk("rst_valid", {31'd0, valid_id}, 32'd0);
        chk("rst_cnt", fetch_count, 32'd0);
        rst_n = 1; tick();
        chk("w0", instr_id, 32'hDEAD_BEEF);
        chk("w0_pp4", pc_plus4_id, 32'd4);
        chk("w0_valid", {31'd0, valid_id}, 32'd1);
        tick();
        chk("w1", instr_id, 32'hDEAD_BEEB);
        stall = 1; tick(); tick();
        chk("stall_instr", instr_id, 32'hDEAD_BEEB);
        chk("stall_pc", imem_addr, 32'd8);
        chk("stall_cnt", fetch_count, 32'd2);
        stall = 0; tick();
        chk("w2", instr_id, 32'hDEAD_BEE7);
        tick();
        chk("w3", instr_id, 32'hDEAD_BEE3);
        chk("seq_addr", imem_addr, 32'd16);
        chk("seq_cnt", fetch_count, 32'd4);
        branch_taken = 1; branch_target = 32'h1000_0004; tick();
        branch_taken = 0; tick();
        chk("jsetup_pp4", pc_plus4_id, 32'h1000_0008);
        jump_en = 1; jump_addr = 26'h0000040; stall = 1; tick();
        chk("jstall_pc", imem_addr, 32'h1000_0008);
        chk("jstall_valid", {31'd0, valid_id}, 32'd1);
        stall = 0; tick();
        chk("jump_pc", imem_addr, 32'h1000_0100);
        chk("jump_valid", {31'd0, valid_id}, 32'd0);
        jump_en = 0; tick();
        branch_taken = 1; branch_target = 32'h0000_0200; jump_en = 1; stall = 1; tick();
        chk("bjs_pc", imem_addr, 32'h0000_0200);
        chk("bjs_valid", {31'd0, valid_id}, 32'd0);
        chk("bjs_cnt", fetch_count, 32'd6);
        jump_en = 0; stall = 0; branch_target = 32'hFFFF_FFFC; tick();
        branch_taken = 0; tick();
        chk("wrap_pc", imem_addr, 32'h0);
        chk("wrap_pp4", pc_plus4_id, 32'h0);
        tick(); stall = 1; tick();
        chk("pre_rst_pc", imem_addr, 32'h4);
        rst_n = 0; tick();
        chk("mid_rst_pc", imem_addr, 32'h0);
        chk("mid_rst_valid", {31'd0, valid_id}, 32'd0);
        chk("mid_rst_cnt", fetch_count, 32'd0);
        rst_n = 1; stall = 0; tick(); tick(); tick();
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
